// File: rtl/gray_codec_pkg.sv
// Shared constants for the Gray code converter and its seven-segment display path.
package gray_codec_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_OFF   = 7'b1111111;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

endpackage

// File: rtl/gray_codec_display_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
  import gray_codec_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nib,
  output logic [SEG_W-1:0]    seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/gray_codec_display.sv
// Registered binary/Gray converter driving parallel and scanned hex seven-segment outputs.
module gray_codec_display
  import gray_codec_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          mode,
  input  logic [WIDTH-1:0]              data_in,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              data_out,
  output logic [SEG_W*(WIDTH/4)-1:0]    seg_all,
  output logic [SEG_W-1:0]              seg_scan,
  output logic [(WIDTH/4)-1:0]          an
);

  localparam int unsigned NDIG  = WIDTH / 4;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned NSLOT = 1 << IDX_W;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || SCAN_DIV < 1) begin : g_param_check
    $error("gray_codec_display: WIDTH must be a multiple of 4 (>=4) and SCAN_DIV >= 1");
  end

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  // Prefix XOR from the MSB down; each bit depends on the one above it
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PRE_W-1:0]             prescaler;
  logic [IDX_W-1:0]             index;
  logic [NSLOT-1:0][SEG_W-1:0]  dig_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= (mode == MODE_G2B) ? gray2bin(data_in) : bin2gray(data_in);
      end
    end
  end

  // Free-running scan: hold each digit for SCAN_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      index     <= '0;
    end else if (prescaler == PRE_W'(SCAN_DIV - 1)) begin
      prescaler <= '0;
      index     <= (index == IDX_W'(NDIG - 1)) ? '0 : index + IDX_W'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    hex7seg u_hex (
      .nib (data_out[4*k +: 4]),
      .seg (dig_seg[k])
    );
    assign seg_all[SEG_W*k +: SEG_W] = dig_seg[k];
  end

  // Pad unused mux slots so a non-power-of-two digit count indexes safely
  for (genvar k = NDIG; k < NSLOT; k++) begin : g_pad
    assign dig_seg[k] = SEG_OFF;
  end

  assign seg_scan = dig_seg[index];
  assign an       = ~(NDIG'(1) << index);

endmodule

// File: tb/tb_gray_codec_display.sv
// Directed self-checking bench for gray_codec_display (8-bit scanned and 4-bit single-digit builds).
module tb_gray_codec_display;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        mode;
  logic [7:0]  data_in;
  logic        out_valid;
  logic [7:0]  data_out;
  logic [13:0] seg_all;
  logic [6:0]  seg_scan;
  logic [1:0]  an;

  logic        in_valid4;
  logic        mode4;
  logic [3:0]  data_in4;
  logic        out_valid4;
  logic [3:0]  data_out4;
  logic [6:0]  seg_all4;
  logic [6:0]  seg_scan4;
  logic [0:0]  an4;

  int checks;
  int failures;

  gray_codec_display #(.WIDTH(8), .SCAN_DIV(4)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out),
    .seg_all   (seg_all),
    .seg_scan  (seg_scan),
    .an        (an)
  );

  gray_codec_display #(.WIDTH(4), .SCAN_DIV(1)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .mode      (mode4),
    .data_in   (data_in4),
    .out_valid (out_valid4),
    .data_out  (data_out4),
    .seg_all   (seg_all4),
    .seg_scan  (seg_scan4),
    .an        (an4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; mode = 1'b0; data_in = 8'h00;
    in_valid4 = 1'b0; mode4 = 1'b0; data_in4 = 4'h0;
    tick();
    tick();
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (an !== 2'b10) begin failures++; $display("FAIL reset_an got=%b exp=10", an); end
    checks++; if (seg_all !== 14'b1000000_1000000) begin failures++; $display("FAIL reset_seg_all got=%b exp=10000001000000", seg_all); end
    checks++; if (seg_scan !== 7'b1000000) begin failures++; $display("FAIL reset_seg_scan got=%b exp=1000000", seg_scan); end
    checks++; if (data_out4 !== 4'h0 || an4 !== 1'b0) begin failures++; $display("FAIL reset_w4 got data=%h an=%b exp data=0 an=0", data_out4, an4); end
    rst = 1'b0;
  endtask

  task automatic test_b2g();
    mode = 1'b0; data_in = 8'hB7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (data_out !== 8'hEC) begin failures++; $display("FAIL b2g_data got=%h exp=ec", data_out); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2g_valid got=%b exp=1", out_valid); end
    checks++; if (seg_all !== 14'b0000110_1000110) begin failures++; $display("FAIL b2g_seg_all got=%b exp=00001101000110", seg_all); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2g_pulse got=%b exp=0", out_valid); end
    checks++; if (data_out !== 8'hEC) begin failures++; $display("FAIL b2g_hold got=%h exp=ec", data_out); end
  endtask

  task automatic test_g2b();
    mode = 1'b1; data_in = 8'hEC; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (data_out !== 8'hB7 || out_valid !== 1'b1) begin failures++; $display("FAIL g2b_data got=%h v=%b exp=b7 v=1", data_out, out_valid); end
    checks++; if (seg_all !== 14'b0000011_1111000) begin failures++; $display("FAIL g2b_seg_all got=%b exp=00000111111000", seg_all); end
    tick();
  endtask

  // Reference forms deliberately differ from a bitwise loop
  task automatic test_sweep();
    logic [7:0] g_exp;
    logic [7:0] v;
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      g_exp = v ^ (v >> 1);
      mode = 1'b0; data_in = v; in_valid = 1'b1;
      tick();
      checks++; if (data_out !== g_exp) begin failures++; bad++; if (bad < 8) $display("FAIL sweep_b2g in=%h got=%h exp=%h", v, data_out, g_exp); end
      mode = 1'b1; data_in = g_exp;
      tick();
      checks++; if (data_out !== v) begin failures++; bad++; if (bad < 8) $display("FAIL sweep_roundtrip in=%h got=%h exp=%h", v, data_out, v); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_width4();
    mode4 = 1'b0; data_in4 = 4'hF; in_valid4 = 1'b1;
    tick();
    checks++; if (data_out4 !== 4'h8 || out_valid4 !== 1'b1) begin failures++; $display("FAIL w4_b2g got=%h v=%b exp=8 v=1", data_out4, out_valid4); end
    checks++; if (seg_all4 !== 7'b0000000 || seg_scan4 !== 7'b0000000) begin failures++; $display("FAIL w4_seg got=%b/%b exp=0000000", seg_all4, seg_scan4); end
    mode4 = 1'b1; data_in4 = 4'h8;
    tick();
    in_valid4 = 1'b0;
    checks++; if (data_out4 !== 4'hF || seg_all4 !== 7'b0001110) begin failures++; $display("FAIL w4_g2b got=%h seg=%b exp=f seg=0001110", data_out4, seg_all4); end
    checks++; if (an4 !== 1'b0) begin failures++; $display("FAIL w4_an got=%b exp=0", an4); end
  endtask

  task automatic test_scan();
    logic [1:0] prev_an;
    bit found;
    mode = 1'b0; data_in = 8'hB7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    prev_an = an;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (prev_an == 2'b01 && an == 2'b10) found = 1'b1;
      else prev_an = an;
    end
    checks++; if (!found) begin failures++; $display("FAIL scan_sync got=no_transition exp=transition_within_20"); end
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      if (c < 4 || c == 8) begin
        checks++; if (an !== 2'b10 || seg_scan !== 7'b1000110) begin failures++; $display("FAIL scan_digit0 cyc=%0d got an=%b seg=%b exp an=10 seg=1000110", c, an, seg_scan); end
      end else begin
        checks++; if (an !== 2'b01 || seg_scan !== 7'b0000110) begin failures++; $display("FAIL scan_digit1 cyc=%0d got an=%b seg=%b exp an=01 seg=0000110", c, an, seg_scan); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h01; exp_q[1] = 8'h03; exp_q[2] = 8'h02;
    mode = 1'b0; in_valid = 1'b1; data_in = 8'h01;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin data_in = 8'h04; rst = 1'b1; end
      else data_in = 8'(k + 2);
      checks++; if (data_out !== exp_q[k] || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_%0d got=%h v=%b exp=%h v=1", k, data_out, out_valid, exp_q[k]); end
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    checks++; if (data_out !== 8'h00 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_rst got=%h v=%b exp=00 v=0", data_out, out_valid); end
    checks++; if (dut8.prescaler !== 2'd0 || an !== 2'b10) begin failures++; $display("FAIL b2b_rst_scan got pre=%0d an=%b exp pre=0 an=10", dut8.prescaler, an); end
    // Prescaler restarts from 0: digit 0 for exactly 4 samples, then digit 1
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 4) begin
        checks++; if (an !== 2'b10) begin failures++; $display("FAIL rst_scan_hold cyc=%0d got=%b exp=10", c, an); end
      end else begin
        checks++; if (an !== 2'b01) begin failures++; $display("FAIL rst_scan_adv got=%b exp=01", an); end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_b2g();
    test_g2b();
    test_width4();
    test_sweep();
    test_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_codec_display.md
# gray_codec_display

Parametrised, registered binary/Gray code converter with multi-digit hexadecimal seven-segment output. Converts a WIDTH-bit word either binary→Gray or Gray→binary, chosen per transaction. Holds the result and drives it both as parallel per-digit segment patterns and as a time-multiplexed scan for shared-segment display boards. Sits between the switch/input sampling logic and the board's seven-segment digits.

## Interface
- WIDTH, 8, data word width in bits; multiple of 4, minimum 4; NDIG = WIDTH/4 digits
- SCAN_DIV, 50000, clock cycles each digit stays enabled in scan mode; minimum 1
- clk  input  1  single system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  capture data_in and mode this cycle
- mode  input  1  0 = binary→Gray, 1 = Gray→binary
- data_in  input  WIDTH  word to convert
- out_valid  output  1  one-cycle pulse: data_out updated this cycle
- data_out  output  WIDTH  last converted word (held)
- seg_all  output  7*NDIG  active-low patterns; bits [7k+6:7k] show nibble k of data_out
- seg_scan  output  7  active-low pattern of the currently scanned digit
- an  output  NDIG  active-low digit enable; exactly one bit low at all times

## Operation
- Binary→Gray: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] ^ b[i] for i < WIDTH-1.
- Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] (prefix XOR from MSB down).
- in_valid high: converted value registered into data_out; mode sampled the same cycle. in_valid low: data_out holds.
- No backpressure. Back-to-back in_valid accepted every cycle.
- Hex decode per nibble, active-low, segment order {g,f,e,d,c,b,a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Scan: prescaler counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and digit index advances, wrapping NDIG-1→0. an = ~(1 << index); seg_scan = pattern of nibble[index].
- Scan runs freely, independent of in_valid.

## Timing
- Latency 1: in_valid at edge N → data_out and out_valid valid after edge N+1. out_valid is low in every cycle without a prior-cycle capture.
- seg_all and seg_scan are combinational from the data_out/index registers; same cycle as data_out.
- Reset values: data_out = 0; out_valid = 0; seg_all = 1000000 per digit; prescaler = 0; index = 0; an = all ones except bit 0; seg_scan = 1000000.
- rst has priority over in_valid. A rst asserted while in_valid is high discards the capture, and out_valid stays 0.
- SCAN_DIV = 1: index advances every cycle.
- NDIG = 1: index stays 0, an = 0.

## Structure
- Package gray_codec_pkg:
  - the 16 hex segment constants
  - SEG_OFF = 1111111
  - mode encoding constants: MODE_B2G = 0, MODE_G2B = 1
- Sub-module hex7seg: combinational 4-bit→7-bit decoder. Instantiated NDIG times for seg_all. seg_scan is a mux of those outputs, not an extra decoder.
- Conversion functions live in the top module, in a for-loop over WIDTH.
- Elaboration-time check: WIDTH % 4 == 0 and SCAN_DIV >= 1.

## Test plan
- WIDTH=8, rst held 2 cycles → data_out=0x00, out_valid=0, an=2'b10, seg_all=1000000_1000000.
- mode=0, data_in=0xB7, in_valid 1 cycle → next cycle data_out=0xEC, out_valid=1 for one cycle, seg_all=0000110_1000110.
- mode=1, data_in=0xEC → data_out=0xB7; also sweep all 256 values through both modes; round-trip must equal input.
- WIDTH=4, mode=0, data_in=0xF → data_out=0x8, seg_all=0000000; mode=1, data_in=0x8 → 0xF.
- WIDTH=8, SCAN_DIV=4, data_out=0xEC → an=10 with seg_scan=1000110 for 4 cycles, then an=01 with seg_scan=0000110 for 4 cycles, then repeat.
- Back-to-back in_valid (0x01, 0x02, 0x03, mode=0) → data_out 0x01, 0x03, 0x02 on consecutive cycles. rst coincident with a fourth in_valid → data_out=0x00, out_valid=0, prescaler and index at 0.
